// File: rtl/csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR file: widths, CSR addresses,
// mstatus field positions and the write-masking rules.
package csr_regfile_pkg;

    localparam int XLEN     = 32;
    localparam int PC_WIDTH = 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // MSTATUS_MPP is the low bit of the two-bit MPP field (bits 12:11)
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    function automatic logic [XLEN-1:0] mstatus_pack(input mstatus_t s);
        logic [XLEN-1:0] v;
        v                    = '0;
        v[MSTATUS_MIE]       = s.mie;
        v[MSTATUS_MPIE]      = s.mpie;
        v[MSTATUS_MPP +: 2]  = 2'b11;
        return v;
    endfunction

    function automatic logic csr_is_writable(input logic [11:0] idx);
        case (idx)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Value a write to idx actually stores (and what the read bypass returns)
    function automatic logic [XLEN-1:0] csr_wmask(input logic [11:0] idx,
                                                  input logic [XLEN-1:0] d);
        mstatus_t s;
        s.mie  = d[MSTATUS_MIE];
        s.mpie = d[MSTATUS_MPIE];
        case (idx)
            CSR_MSTATUS:         return mstatus_pack(s);
            CSR_MTVEC, CSR_MEPC: return d & ~XLEN'(3);
            default:             return d;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable halves; a write to either half
// suppresses the increment for that cycle.
module csr_counter64
    import csr_regfile_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            wr_lo_i,
    input  logic            wr_hi_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [63:0]     cnt_o
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) r_cnt[31:0]  <= wdata_i;
            if (wr_hi_i) r_cnt[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read port with write bypass, writeback
// commit, trap entry / mret handling and the cycle/instret counters.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [XLEN-1:0] MHARTID_VAL = '0,
    parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [11:0]         csr_ridx_i,
    output logic [XLEN-1:0]     csr_rdata_o,
    input  logic                csr_we_i,
    input  logic [11:0]         csr_widx_i,
    input  logic [XLEN-1:0]     csr_wdata_i,
    input  logic                instret_i,
    input  logic                trap_i,
    input  logic [PC_WIDTH-1:0] trap_pc_i,
    input  logic [XLEN-1:0]     trap_cause_i,
    input  logic                mret_i,
    output logic [PC_WIDTH-1:0] mtvec_o,
    output logic [PC_WIDTH-1:0] mepc_o,
    output logic                mie_o
);

    mstatus_t            r_mstatus;
    logic [XLEN-1:0]     r_mtvec;
    logic [PC_WIDTH-1:0] r_mepc;
    logic [XLEN-1:0]     r_mcause;
    logic [XLEN-1:0]     r_mscratch;

    logic [XLEN-1:0]     w_wval;
    logic [XLEN-1:0]     w_cur;
    logic                w_bypass;
    logic [63:0]         w_cycle;
    logic [63:0]         w_instret;

    logic w_wr_mstatus, w_wr_mtvec, w_wr_mscratch, w_wr_mepc, w_wr_mcause;
    logic w_wr_cyc_lo, w_wr_cyc_hi, w_wr_ins_lo, w_wr_ins_hi;

    assign w_wval        = csr_wmask(csr_widx_i, csr_wdata_i);
    assign w_wr_mstatus  = csr_we_i && (csr_widx_i == CSR_MSTATUS);
    assign w_wr_mtvec    = csr_we_i && (csr_widx_i == CSR_MTVEC);
    assign w_wr_mscratch = csr_we_i && (csr_widx_i == CSR_MSCRATCH);
    assign w_wr_mepc     = csr_we_i && (csr_widx_i == CSR_MEPC);
    assign w_wr_mcause   = csr_we_i && (csr_widx_i == CSR_MCAUSE);
    assign w_wr_cyc_lo   = csr_we_i && (csr_widx_i == CSR_MCYCLE);
    assign w_wr_cyc_hi   = csr_we_i && (csr_widx_i == CSR_MCYCLEH);
    assign w_wr_ins_lo   = csr_we_i && (csr_widx_i == CSR_MINSTRET);
    assign w_wr_ins_hi   = csr_we_i && (csr_widx_i == CSR_MINSTRETH);

    csr_counter64 u_cycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (w_wr_cyc_lo),
        .wr_hi_i (w_wr_cyc_hi),
        .wdata_i (csr_wdata_i),
        .cnt_o   (w_cycle)
    );

    csr_counter64 u_instret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wr_lo_i (w_wr_ins_lo),
        .wr_hi_i (w_wr_ins_hi),
        .wdata_i (csr_wdata_i),
        .cnt_o   (w_instret)
    );

    // Trap outranks mret, which outranks a software write, per register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mstatus  <= '0;
            r_mtvec    <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mscratch <= '0;
        end else begin
            if (w_wr_mtvec)    r_mtvec    <= w_wval;
            if (w_wr_mscratch) r_mscratch <= w_wval;
            if (trap_i) begin
                r_mepc         <= trap_pc_i & ~PC_WIDTH'(3);
                r_mcause       <= trap_cause_i;
                r_mstatus.mpie <= r_mstatus.mie;
                r_mstatus.mie  <= 1'b0;
            end else begin
                if (w_wr_mepc)   r_mepc   <= w_wval[PC_WIDTH-1:0];
                if (w_wr_mcause) r_mcause <= w_wval;
                if (mret_i) begin
                    r_mstatus.mie  <= r_mstatus.mpie;
                    r_mstatus.mpie <= 1'b1;
                end else if (w_wr_mstatus) begin
                    r_mstatus.mie  <= w_wval[MSTATUS_MIE];
                    r_mstatus.mpie <= w_wval[MSTATUS_MPIE];
                end
            end
        end
    end

    always_comb begin
        w_cur = '0;
        case (csr_ridx_i)
            CSR_MSTATUS:                  w_cur = mstatus_pack(r_mstatus);
            CSR_MISA:                     w_cur = MISA_VAL;
            CSR_MHARTID:                  w_cur = MHARTID_VAL;
            CSR_MTVEC:                    w_cur = r_mtvec;
            CSR_MSCRATCH:                 w_cur = r_mscratch;
            CSR_MEPC:                     w_cur = XLEN'(r_mepc);
            CSR_MCAUSE:                   w_cur = r_mcause;
            CSR_MCYCLE,   CSR_CYCLE:      w_cur = w_cycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:     w_cur = w_cycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:    w_cur = w_instret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  w_cur = w_instret[63:32];
            default:                      w_cur = '0;
        endcase
    end

    assign w_bypass    = csr_we_i && (csr_widx_i == csr_ridx_i) && csr_is_writable(csr_widx_i);
    assign csr_rdata_o = w_bypass ? w_wval : w_cur;

    assign mtvec_o = r_mtvec[PC_WIDTH-1:0];
    assign mepc_o  = r_mepc;
    assign mie_o   = r_mstatus.mie;

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file and the responder for the execute stage's CSR access. The execute stage presents a CSR index and receives read data in the same cycle. Writeback commits CSR writes, trap entry and `mret`. The block supplies `mtvec`/`mepc` to the fetch redirect logic and keeps the 64-bit cycle and instret counters.

## Interface
- `XLEN` (global define), 32: data width; all CSRs are `XLEN` bits.
- `PC_WIDTH` (global define), 32: PC width.
- `MHARTID_VAL`, 0: value read from `mhartid`.
- `MISA_VAL`, 32'h4000_0100: value read from `misa` (RV32I).

Ports, one per line:
- `clk_i`  in  1  clock; one clock domain, all state on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `csr_ridx_i`  in  12  read index from the execute stage.
- `csr_rdata_o`  out  XLEN  read data, combinational.
- `csr_we_i`  in  1  write strobe from writeback.
- `csr_widx_i`  in  12  write index.
- `csr_wdata_i`  in  XLEN  final write value; RS/RC merging is already done upstream.
- `instret_i`  in  1  one instruction retired this cycle.
- `trap_i`  in  1  trap entry this cycle.
- `trap_pc_i`  in  PC_WIDTH  PC of the trapping instruction.
- `trap_cause_i`  in  XLEN  cause value.
- `mret_i`  in  1  `mret` retiring this cycle.
- `mtvec_o`  out  PC_WIDTH  trap vector base, registered value.
- `mepc_o`  out  PC_WIDTH  return PC, registered value.
- `mie_o`  out  1  `mstatus.MIE`.

## Operation
**Implemented CSRs**
- `mstatus` 0x300: MIE bit 3 and MPIE bit 7 are writable; MPP bits 12:11 are hardwired to 2'b11; all other bits read 0.
- `misa` 0x301 and `mhartid` 0xF14: read-only; writes are ignored.
- `mtvec` 0x305: direct mode only; bits 1:0 are forced to 0 on write.
- `mscratch` 0x340: fully writable.
- `mepc` 0x341: bits 1:0 are forced to 0.
- `mcause` 0x342: fully writable.
- `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: the two halves of each 64-bit counter.
- `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only aliases of the counters.

**Reads and writes**
- Unimplemented index: reads 0; writes are ignored. No illegal-instruction signalling from this block.
- Read bypass: if `csr_we_i` is high and `csr_widx_i == csr_ridx_i`, then `csr_rdata_o = csr_wdata_i` after masking, as it will be stored. Otherwise `csr_rdata_o` is the current register value.

**Counters**
- `mcycle` increments every cycle that is not reset.
- `minstret` increments when `instret_i` is high.
- Both are 64-bit. A carry out of the low half increments the high half in the same cycle. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A software write to either half replaces that half. That counter does not increment in that cycle, and the other half holds.

**Trap entry** (`trap_i`)
- `mepc <= trap_pc_i` with bits 1:0 cleared.
- `mcause <= trap_cause_i`.
- `MPIE <= MIE`, `MIE <= 0`.

**`mret`** (`mret_i`)
- `MIE <= MPIE`, `MPIE <= 1`.

**Priority per cycle**
- Trap beats `mret` beats a CSR write to `mstatus`/`mepc`/`mcause`. The losing update to those registers is dropped.
- A CSR write to an unaffected register (e.g. `mscratch`) still commits alongside a trap or `mret`.

## Timing
- Read latency is 0 cycles (combinational).
- Write, trap and `mret` effects are visible on the register outputs one cycle after the strobe.
- Reset values, applied at the first edge with `rst_i` high:
  - `mstatus` = 0x0000_1800; `mie_o` = 0.
  - `mtvec`, `mepc`, `mcause`, `mscratch` = 0; `mtvec_o` = `mepc_o` = 0.
  - All counters = 0.
- Reset overrides every simultaneous strobe; counters do not count in a reset cycle.
- Reset asserted mid-operation discards pending writes and a trap in the same cycle.
- No handshake exists: strobes are single-cycle pulses that are never back-pressured. Every cycle with a strobe high is a separate event.

## Structure
- The shared defines file holds:
  - CSR address constants (`CSR_MSTATUS`, `CSR_MTVEC`, …, `CSR_MINSTRETH`).
  - `mstatus` bit positions (`MSTATUS_MIE`, `MSTATUS_MPIE`, `MSTATUS_MPP`).
  - `PC_WIDTH` and `XLEN`.
- Sub-module `csr_counter64`, instantiated twice (cycle and instret), with ports:
  - `clk_i`, `rst_i`, `inc_i`;
  - `wr_lo_i`, `wr_hi_i`, `wdata_i`;
  - `cnt_o[63:0]`.
- Read mux and write decode live in `csr_regfile`.

## Test plan
- **Reset:** after reset, reading 0x300 gives 0x0000_1800; reading 0x305, 0x341 and 0xB00 gives 0; `mie_o` = 0.
- **Write and bypass:** write `mtvec` = 0x8000_0103. In the same cycle, read 0x305 → 0x8000_0100 (bypass). Next cycle `mtvec_o` = 0x8000_0100.
- **Trap then `mret`:** set MIE = 1, then pulse `trap_i` with pc 0x0000_1006 and cause 0xB. Next cycle:
  - `mepc_o` = 0x0000_1004, `mcause` = 0xB;
  - `mstatus` = 0x0000_1880, `mie_o` = 0.
  Then pulse `mret_i` → `mstatus` = 0x0000_1888, `mie_o` = 1.
- **Counter carry and wrap:**
  - Write `mcycle` = 0xFFFF_FFFF, `mcycleh` = 0. Two cycles later `mcycleh` = 1, `mcycle` = 0.
  - Preset both halves to all ones → they wrap to 0 the next cycle.
- **Simultaneous events:** in one cycle pulse `trap_i`, `mret_i`, a write to `mepc` = 0x100 and a write to `mscratch` = 0x55. Result:
  - the trap values win;
  - `mscratch` = 0x55;
  - `minstret` does not increment while `instret_i` is 0.
- **Unimplemented index:** write 0x7C0 = 0x1234, then read it → 0. No other CSR changes.
